// File: rtl/tx_bit_serializer.sv
// Byte-to-bit serializer for the 1 Mbit/s TX PHY path: an 8-bit shift register
// plus an 8-bit holding register, LSB-first output, optional BLE data whitening.
module tx_bit_serializer #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  input  logic       whiten_en,
  input  logic [5:0] channel_number,
  output logic       phy_bit,
  output logic       bit_valid,
  output logic       bit_valid_last,
  output logic       busy,
  output logic       underrun
);

  localparam int TW = $clog2(CLK_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLK_PER_BIT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    sr_q, sr_d;
  logic          sr_last_q, sr_last_d;
  logic          sr_done_q, sr_done_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    hr_q, hr_d;
  logic          hr_last_q, hr_last_d;
  logic          hr_full_q, hr_full_d;
  logic          last_seen_q, last_seen_d;
  logic          wen_q, wen_d;
  logic [6:0]    lfsr_q, lfsr_d;
  logic          phy_bit_q, phy_bit_d;
  logic          bit_valid_q, bit_valid_d;
  logic          bit_last_q, bit_last_d;
  logic          busy_q, busy_d;
  logic          underrun_q, underrun_d;

  logic [7:0] cur_byte;
  logic       cur_last;
  logic [2:0] cur_idx;
  logic       strobe_slot, starve, accept, w;

  // Once the SR byte is fully sent, the next strobe draws bit 0 straight from HR.
  assign cur_byte    = sr_done_q ? hr_q      : sr_q;
  assign cur_last    = sr_done_q ? hr_last_q : sr_last_q;
  assign cur_idx     = sr_done_q ? 3'd0      : idx_q;
  assign strobe_slot = (state_q == RUN) && (timer_q == '0);
  assign starve      = strobe_slot && sr_done_q && !hr_full_q;
  assign w           = lfsr_q[6];

  // A byte arriving in the starve slot is too late for this packet; refusing it
  // lets it start the next packet instead of being dropped by the underrun exit.
  assign byte_ready = ~hr_full_q & ~last_seen_q & ~starve;
  assign accept     = byte_valid & byte_ready;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    sr_d        = sr_q;
    sr_last_d   = sr_last_q;
    sr_done_d   = sr_done_q;
    idx_d       = idx_q;
    hr_d        = hr_q;
    hr_last_d   = hr_last_q;
    hr_full_d   = hr_full_q;
    last_seen_d = last_seen_q;
    wen_d       = wen_q;
    lfsr_d      = lfsr_q;
    phy_bit_d   = phy_bit_q;
    bit_valid_d = 1'b0;
    bit_last_d  = 1'b0;
    busy_d      = (state_q == RUN);
    underrun_d  = underrun_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = RUN;
          timer_d     = '0;
          sr_d        = byte_in;
          sr_last_d   = byte_last;
          sr_done_d   = 1'b0;
          idx_d       = 3'd0;
          hr_full_d   = 1'b0;
          last_seen_d = byte_last;
          wen_d       = whiten_en;
          lfsr_d      = {channel_number[0], channel_number[1], channel_number[2],
                         channel_number[3], channel_number[4], channel_number[5], 1'b1};
          underrun_d  = 1'b0;
        end
      end
      RUN: begin
        timer_d = (timer_q == TMAX) ? '0 : timer_q + TW'(1);
        if (starve) begin
          underrun_d  = 1'b1;
          state_d     = IDLE;
          last_seen_d = 1'b0;
        end else if (strobe_slot) begin
          bit_valid_d = 1'b1;
          phy_bit_d   = cur_byte[0] ^ (w & wen_q);
          lfsr_d      = {lfsr_q[5], lfsr_q[4], lfsr_q[3] ^ w, lfsr_q[2], lfsr_q[1], lfsr_q[0], w};
          sr_d        = {1'b0, cur_byte[7:1]};
          sr_last_d   = cur_last;
          idx_d       = cur_idx + 3'd1;
          sr_done_d   = (cur_idx == 3'd7);
          if (sr_done_q) hr_full_d = 1'b0;
          if ((cur_idx == 3'd7) && cur_last) begin
            bit_last_d  = 1'b1;
            state_d     = IDLE;
            last_seen_d = 1'b0;
          end
        end
        if (accept) begin
          hr_d      = byte_in;
          hr_last_d = byte_last;
          hr_full_d = 1'b1;
          if (byte_last) last_seen_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      sr_q        <= '0;
      sr_last_q   <= 1'b0;
      sr_done_q   <= 1'b0;
      idx_q       <= 3'd0;
      hr_q        <= '0;
      hr_last_q   <= 1'b0;
      hr_full_q   <= 1'b0;
      last_seen_q <= 1'b0;
      wen_q       <= 1'b0;
      lfsr_q      <= '0;
      phy_bit_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      sr_q        <= sr_d;
      sr_last_q   <= sr_last_d;
      sr_done_q   <= sr_done_d;
      idx_q       <= idx_d;
      hr_q        <= hr_d;
      hr_last_q   <= hr_last_d;
      hr_full_q   <= hr_full_d;
      last_seen_q <= last_seen_d;
      wen_q       <= wen_d;
      lfsr_q      <= lfsr_d;
      phy_bit_q   <= phy_bit_d;
      bit_valid_q <= bit_valid_d;
      bit_last_q  <= bit_last_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

  assign phy_bit        = phy_bit_q;
  assign bit_valid      = bit_valid_q;
  assign bit_valid_last = bit_last_q;
  assign busy           = busy_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_tx_bit_serializer.sv
// Randomized bench for tx_bit_serializer: a queue-based packet model checks every
// output each cycle, plus literal checks for the reference scenarios.
module tb_tx_bit_serializer;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_last = 1'b0;
  logic       whiten_en = 1'b0;
  logic [5:0] channel_number = 6'd0;
  logic       byte_ready, phy_bit, bit_valid, bit_valid_last, busy, underrun;

  tx_bit_serializer #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready), .whiten_en(whiten_en),
    .channel_number(channel_number), .phy_bit(phy_bit), .bit_valid(bit_valid),
    .bit_valid_last(bit_valid_last), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] whiten_step(input logic [6:0] s);
    logic b;
    b = s[6];
    return {s[5], s[4], s[3] ^ b, s[2], s[1], s[0], b};
  endfunction

  // Reference model: bytes of the current packet in a queue (head = byte being sent,
  // second entry = waiting byte), strobes scheduled at absolute cycle numbers.
  bit         m_run = 0;
  bit         m_lastacc = 0;
  bit         m_wen = 0;
  int         m_cyc = 0;
  int         m_dec = 0;
  int         m_nb = 0;
  logic [8:0] m_q[$];
  logic [8:0] m_h;
  logic [6:0] m_s = '0;
  bit         exp_rdy;
  logic       e_bit = 0, e_bv = 0, e_bl = 0, e_busy = 0, e_und = 0;
  logic       n_bit, n_bv, n_bl, n_busy, n_und;

  always @(negedge clk) begin
    if (rst) begin
      m_run = 0; m_lastacc = 0; m_cyc = 0; m_nb = 0; m_q.delete();
      e_bit = 0; e_bv = 0; e_bl = 0; e_busy = 0; e_und = 0;
    end else begin
      m_cyc++;
      exp_rdy = !m_run || (m_q.size() < 2 && !m_lastacc &&
                           !(m_cyc == m_dec && m_nb == 8 && m_q.size() == 1));
      chk("byte_ready", byte_ready, exp_rdy);
      chk("phy_bit", phy_bit, e_bit);
      chk("bit_valid", bit_valid, e_bv);
      chk("bit_valid_last", bit_valid_last, e_bl);
      chk("busy", busy, e_busy);
      chk("underrun", underrun, e_und);

      n_busy = m_run; n_bv = 0; n_bl = 0; n_bit = e_bit; n_und = e_und;
      if (!m_run) begin
        if (byte_valid) begin
          m_q.delete();
          m_q.push_back({byte_last, byte_in});
          m_nb = 0; m_dec = m_cyc + 1; m_run = 1;
          m_lastacc = byte_last; m_wen = whiten_en; n_und = 0;
          m_s[0] = 1'b1;
          for (int i = 1; i < 7; i++) m_s[i] = channel_number[6 - i];
        end
      end else begin
        if (m_cyc == m_dec) begin
          if (m_nb == 8) begin
            void'(m_q.pop_front());
            m_nb = 0;
            if (m_q.size() == 0) begin n_und = 1; m_run = 0; m_lastacc = 0; end
          end
          if (m_run) begin
            m_h = m_q[0];
            n_bit = m_h[m_nb] ^ (m_s[6] & m_wen);
            m_s = whiten_step(m_s);
            m_nb++; n_bv = 1; m_dec += CPB;
            if (m_nb == 8 && m_h[8]) begin n_bl = 1; m_run = 0; m_lastacc = 0; m_q.delete(); end
          end
        end
        if (exp_rdy && byte_valid) begin
          m_q.push_back({byte_last, byte_in});
          if (byte_last) m_lastacc = 1;
        end
      end
      e_bit = n_bit; e_bv = n_bv; e_bl = n_bl; e_busy = n_busy; e_und = n_und;
    end
  end

  int   abs_cyc = 0;
  logic mon_bits[$];
  logic mon_last[$];
  int   mon_t[$];

  always @(negedge clk) begin
    abs_cyc++;
    if (!rst && bit_valid === 1'b1) begin
      mon_bits.push_back(phy_bit);
      mon_last.push_back(bit_valid_last);
      mon_t.push_back(abs_cyc);
    end
  end

  task automatic mon_clear();
    mon_bits.delete(); mon_last.delete(); mon_t.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    bit ok;
    ok = 0;
    byte_in = b; byte_last = l; byte_valid = 1'b1;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) ok = 1;
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    chk("accept_within_bound", ok, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 800 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && bit_valid === 1'b0 && !m_run) done = 1;
    end
    chk("idle_within_bound", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  logic [7:0]  v8;
  logic [23:0] exp24;
  logic [7:0]  a5;
  int          nl, len, gap;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_phy_bit", phy_bit, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_bit_valid_last", bit_valid_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_byte_ready", byte_ready, 1);
    repeat (2) @(posedge clk); #1;

    // Single byte 0xA5, strobes at T+1+16k, busy drops at T+114
    a5 = 8'hA5;
    whiten_en = 1'b0; channel_number = 6'd0;
    send_byte(8'hA5, 1'b1);
    for (int j = 1; j <= 114; j++) begin
      @(posedge clk); #1;
      if (j <= 113 && (j - 1) % 16 == 0) begin
        chk("a5_strobe", bit_valid, 1);
        chk("a5_bit", phy_bit, a5[(j - 1) / 16]);
        chk("a5_last", bit_valid_last, (j == 113));
      end
      if (j == 113) chk("a5_busy_hi", busy, 1);
      if (j == 114) begin
        chk("a5_busy_lo", busy, 0);
        chk("a5_no_strobe", bit_valid, 0);
      end
    end
    wait_idle();

    // Whitening of 0x00 on channel 0
    mon_clear();
    whiten_en = 1'b1; channel_number = 6'd0;
    send_byte(8'h00, 1'b1);
    wait_idle();
    chk("whiten_count", mon_bits.size(), 8);
    v8 = '0;
    for (int i = 0; i < mon_bits.size() && i < 8; i++) v8[i] = mon_bits[i];
    chk("whiten_byte", v8, 8'h40);

    // Gap-free three-byte packet with valid held high
    mon_clear();
    whiten_en = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    chk("ready_low_hr_full", byte_ready, 0);
    send_byte(8'h03, 1'b1);
    @(posedge clk); #1;
    chk("ready_low_after_last", byte_ready, 0);
    wait_idle();
    exp24 = 24'h030201;
    chk("three_count", mon_bits.size(), 24);
    nl = 0;
    for (int i = 0; i < mon_bits.size() && i < 24; i++) begin
      chk("three_bit", mon_bits[i], exp24[i]);
      chk("three_last", mon_last[i], (i == 23));
      if (i > 0) chk("three_spacing", mon_t[i] - mon_t[i - 1], CPB);
    end

    // Underrun: second byte withheld
    mon_clear();
    send_byte(8'h5A, 1'b0);
    repeat (200) @(posedge clk);
    #1;
    chk("ur_count", mon_bits.size(), 8);
    chk("ur_flag", underrun, 1);
    chk("ur_busy", busy, 0);
    nl = 0;
    foreach (mon_last[i]) nl += mon_last[i];
    chk("ur_no_last", nl, 0);
    send_byte(8'h33, 1'b1);
    chk("ur_cleared", underrun, 0);
    wait_idle();

    // Asynchronous reset mid-packet
    send_byte(8'hC3, 1'b1);
    repeat (40) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_phy_bit", phy_bit, 0);
    chk("arst_bit_valid", bit_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_byte_ready", byte_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_clear();
    repeat (60) @(posedge clk);
    #1;
    chk("arst_no_strobes", mon_bits.size(), 0);
    chk("arst_busy_after", busy, 0);

    // Randomized packets, occasional long gaps to provoke underruns
    for (int p = 0; p < 40; p++) begin
      whiten_en = 1'($urandom_range(0, 1));
      channel_number = 6'($urandom_range(0, 63));
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        gap = ($urandom_range(0, 14) == 0) ? $urandom_range(140, 180) : $urandom_range(0, 30);
        repeat (gap) @(posedge clk);
        #1;
        send_byte(8'($urandom_range(0, 255)), (b == len - 1));
      end
      wait_idle();
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
